// File: rtl/p7_mem_ctrl.sv
// -----------------------------------------------------------------------------
// p7_mem_ctrl
//   Memory / I/O controller between the CPU memory port and a 256x16
//   synchronous-read RAM. Serves CPU reads and writes, signals completion
//   with a one-cycle mem_ready pulse, and maps switches (SW) and an LED
//   register (LEDR) into the upper half of the 9-bit address space.
//
//   Optional feature macro: P7_PREFETCH_EN
//     When defined, the word after each RAM read is prefetched while the
//     controller sits in RESP, so a sequential fetch completes one cycle
//     sooner. When undefined, every RAM read takes the two-cycle path.
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset_n     in   1   synchronous active-low reset
//   mem_cmd     in   2   00 none, 01 read, 10 write, 11 none
//   mem_addr    in   9   word address; [8]=0 RAM, [8]=1 I/O
//   write_data  in  16   store data from CPU
//   read_data   out 16   registered load data
//   mem_ready   out  1   one-cycle completion pulse
//   ram_addr    out  8   RAM address (combinational)
//   ram_din     out 16   RAM write data (= write_data)
//   ram_we      out  1   RAM write enable (combinational)
//   ram_dout    in  16   RAM read data, one cycle after ram_addr
//   SW          in   8   switch inputs
//   LEDR        out  8   LED register
// -----------------------------------------------------------------------------
module p7_mem_ctrl #(
    parameter logic [8:0] LED_ADDR = 9'h100,
    parameter logic [8:0] SW_ADDR  = 9'h140
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        mem_ready,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    input  logic [15:0] ram_dout,
    input  logic [7:0]  SW,
    output logic [7:0]  LEDR
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RESP    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_read_data;
    logic [7:0]  r_ledr;

    // Command decode; commands are only honoured while idle
    logic w_idle;
    logic w_acc_rd;
    logic w_acc_wr;
    logic w_ram_sel;
    logic w_ram_rd;
    logic w_ram_wr;

    // Prefetch interface seen by the common datapath
    logic        w_pf_hit;
    logic        w_pf_issue;
    logic [7:0]  w_pf_next_addr;
    logic [15:0] w_pf_rdata;

    assign w_idle    = (r_state == S_IDLE);
    assign w_acc_rd  = w_idle && (mem_cmd == 2'b01);
    assign w_acc_wr  = w_idle && (mem_cmd == 2'b10);
    assign w_ram_sel = ~mem_addr[8];
    assign w_ram_rd  = w_acc_rd && w_ram_sel;
    assign w_ram_wr  = w_acc_wr && w_ram_sel;

`ifdef P7_PREFETCH_EN
    logic        r_pf_valid;
    logic        r_pf_pending;
    logic [7:0]  r_pf_addr;
    logic [15:0] r_pf_data;
    logic [7:0]  r_rd_addr;   // address of the last accepted access
    logic        r_rd_ram;    // last accepted access was a RAM read

    // While pending, the prefetched word is on ram_dout this very cycle
    assign w_pf_rdata     = r_pf_pending ? ram_dout : r_pf_data;
    assign w_pf_hit       = w_ram_rd && (r_pf_valid || r_pf_pending) &&
                            ({1'b0, r_pf_addr} == mem_addr);
    assign w_pf_issue     = (r_state == S_RESP) && r_rd_ram;
    assign w_pf_next_addr = r_rd_addr + 8'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pf_valid   <= 1'b0;
            r_pf_pending <= 1'b0;
            r_pf_addr    <= '0;
            r_pf_data    <= '0;
            r_rd_addr    <= '0;
            r_rd_ram     <= 1'b0;
        end else begin
            if (w_acc_rd || w_acc_wr) begin
                r_rd_ram  <= w_ram_rd;
                r_rd_addr <= mem_addr[7:0];
            end
            // Issuing retargets the buffer, so old contents become stale
            if (w_pf_issue) begin
                r_pf_pending <= 1'b1;
                r_pf_valid   <= 1'b0;
                r_pf_addr    <= w_pf_next_addr;
            end
            if (r_pf_pending) begin
                r_pf_data    <= ram_dout;
                r_pf_valid   <= 1'b1;
                r_pf_pending <= 1'b0;
            end
            // A RAM write may alias the buffered word: drop it, and this
            // takes priority over a capture landing on the same edge
            if (w_ram_wr) begin
                r_pf_valid   <= 1'b0;
                r_pf_pending <= 1'b0;
            end
        end
    end
`else
    assign w_pf_hit       = 1'b0;
    assign w_pf_issue     = 1'b0;
    assign w_pf_next_addr = '0;
    assign w_pf_rdata     = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and RAM-side controls
    always_comb begin
        w_state_nxt = r_state;
        ram_addr    = mem_addr[7:0];
        ram_we      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc_rd) begin
                    w_state_nxt = (w_ram_sel && !w_pf_hit) ? S_RD_WAIT : S_RESP;
                end else if (w_acc_wr) begin
                    w_state_nxt = S_RESP;
                end
                ram_we = w_ram_wr && reset_n;
            end
            S_RD_WAIT: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                if (w_pf_issue) begin
                    ram_addr = w_pf_next_addr;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Read data and LED register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_read_data <= '0;
            r_ledr      <= '0;
        end else begin
            if (w_acc_rd) begin
                if (w_ram_sel) begin
                    if (w_pf_hit) begin
                        r_read_data <= w_pf_rdata;
                    end
                end else if (mem_addr == SW_ADDR) begin
                    r_read_data <= {8'h00, SW};
                end else begin
                    r_read_data <= '0;
                end
            end
            if (r_state == S_RD_WAIT) begin
                r_read_data <= ram_dout;
            end
            if (w_acc_wr && (mem_addr == LED_ADDR)) begin
                r_ledr <= write_data[7:0];
            end
        end
    end

    assign read_data = r_read_data;
    assign LEDR      = r_ledr;
    assign ram_din   = write_data;
    assign mem_ready = reset_n && (r_state == S_RESP);

endmodule

// File: tb/tb_p7_mem_ctrl.sv
module tb_p7_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        mem_ready;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout;
    logic [7:0]  SW;
    logic [7:0]  LEDR;

`ifdef P7_PREFETCH_EN
    localparam int unsigned HIT_LAT = 1;
`else
    localparam int unsigned HIT_LAT = 2;
`endif

    always #5 clk = ~clk;

    p7_mem_ctrl #(.LED_ADDR(9'h100), .SW_ADDR(9'h140)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .mem_ready  (mem_ready),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .SW         (SW),
        .LEDR       (LEDR)
    );

    // 256x16 synchronous-read RAM
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        string       tag;
        logic [15:0] data;
        int unsigned lat;
        int unsigned issue;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned we_cnt   = 0;
    int unsigned rdy_cnt  = 0;
    logic [7:0]  exp_we_addr = '0;
    logic [15:0] exp_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every completion
    always @(negedge clk) begin
        exp_t e;
        if (ram_we) begin
            we_cnt++;
            check_val("we_addr", {24'h0, ram_addr}, {24'h0, exp_we_addr});
        end
        if (mem_ready) begin
            rdy_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_ready: got ready at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check_val({e.tag, "_data"}, {16'h0, read_data}, {16'h0, e.data});
                check_val({e.tag, "_lat"}, cyc - e.issue, e.lat);
            end
        end
    end

    // Called at posedge+1 of an idle cycle; returns at posedge+1 of the
    // idle cycle that follows the response, with mem_cmd dropped.
    task automatic xact(input string tag, input logic [1:0] cmd, input logic [8:0] addr,
                        input logic [15:0] wd, input logic [15:0] rd_exp, input int unsigned lat);
        int unsigned we0;
        bit got;
        exp_t e;
        we0 = we_cnt;
        got = 1'b0;
        if (cmd == 2'b01) exp_rd = rd_exp;
        exp_we_addr = addr[7:0];
        e.tag = tag; e.data = exp_rd; e.lat = lat; e.issue = cyc;
        sb.push_back(e);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = wd;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no ready expected ready within 8 cycles", tag);
            sb.delete();
        end
        @(posedge clk);
        #1;
        mem_cmd = 2'b00;
        check_val({tag, "_we"}, we_cnt - we0, (cmd == 2'b10 && !addr[8]) ? 1 : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned r0;
        int unsigned k;
        exp_t e;
        reset_n = 1'b0; mem_cmd = 2'b00; mem_addr = '0; write_data = '0; SW = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", {31'h0, mem_ready}, 0);
        check_val("rst_rdata", {16'h0, read_data}, 0);
        check_val("rst_ledr", {24'h0, LEDR}, 0);
        check_val("rst_we", {31'h0, ram_we}, 0);
        reset_n = 1'b1;

        xact("wr012", 2'b10, 9'h012, 16'hBEEF, 16'h0, 1);
        xact("rd012", 2'b01, 9'h012, 16'h0, 16'hBEEF, 2);
        xact("led5a", 2'b10, 9'h100, 16'h5A5A, 16'h0, 1);
        check_val("led5a_ledr", {24'h0, LEDR}, 32'h5A);

        // Reset during RD_WAIT: transaction abandoned, no ready
        mem_cmd = 2'b01; mem_addr = 9'h034;
        @(posedge clk); #1;
        reset_n = 1'b0; mem_cmd = 2'b00;
        repeat (2) begin
            @(negedge clk);
            check_val("midrst_ready", {31'h0, mem_ready}, 0);
            check_val("midrst_we", {31'h0, ram_we}, 0);
            @(posedge clk); #1;
        end
        check_val("midrst_rdata", {16'h0, read_data}, 0);
        check_val("midrst_ledr", {24'h0, LEDR}, 0);
        reset_n = 1'b1;
        exp_rd = 16'h0;

        SW = 8'hA5;
        xact("sw", 2'b01, 9'h140, 16'h0, 16'h00A5, 1);
        xact("led34", 2'b10, 9'h100, 16'h1234, 16'h0, 1);
        check_val("led34_ledr", {24'h0, LEDR}, 32'h34);
        xact("io_rd", 2'b01, 9'h1FF, 16'h0, 16'h0000, 1);
        xact("io_wr", 2'b10, 9'h180, 16'h9999, 16'h0, 1);
        check_val("io_wr_ledr", {24'h0, LEDR}, 32'h34);

        // mem_cmd=11 is no command
        r0 = rdy_cnt;
        mem_cmd = 2'b11; mem_addr = 9'h012;
        repeat (4) @(posedge clk);
        #1;
        mem_cmd = 2'b00;
        check_val("cmd11_ready", rdy_cnt - r0, 0);

        // Held read: one completion every 3 cycles
        r0 = rdy_cnt;
        k  = cyc;
        for (int i = 0; i < 4; i++) begin
            e.tag = "hold"; e.data = 16'hBEEF; e.lat = 2; e.issue = k + 3 * i;
            sb.push_back(e);
        end
        exp_rd = 16'hBEEF;
        mem_cmd = 2'b01; mem_addr = 9'h012;
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
        mem_cmd = 2'b00;
        check_val("hold_count", rdy_cnt - r0, 4);

        // Sequential reads with address wrap
        xact("wr0ff", 2'b10, 9'h0FF, 16'h1111, 16'h0, 1);
        xact("wr000", 2'b10, 9'h000, 16'h2222, 16'h0, 1);
        xact("rd0ff_a", 2'b01, 9'h0FF, 16'h0, 16'h1111, 2);
        xact("rd000_a", 2'b01, 9'h000, 16'h0, 16'h2222, HIT_LAT);

        // Intervening write invalidates the prefetch
        xact("rd0ff_b", 2'b01, 9'h0FF, 16'h0, 16'h1111, 2);
        xact("wr000_b", 2'b10, 9'h000, 16'h3333, 16'h0, 1);
        xact("rd000_b", 2'b01, 9'h000, 16'h0, 16'h3333, 2);

        // Hit from a settled (valid) prefetch buffer
        xact("rd0ff_c", 2'b01, 9'h0FF, 16'h0, 16'h1111, 2);
        repeat (3) @(posedge clk);
        #1;
        xact("rd000_c", 2'b01, 9'h000, 16'h0, 16'h3333, HIT_LAT);

        repeat (3) @(posedge clk);
        #1;
        check_val("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
